id_ex_stage_register: RTL and testbench

ID/EX pipeline register for the five-stage RISC-V core, with built-in load-use hazard detection and bubble insertion. It sits between the decode stage and the execute stage. It captures decoded operands, register indices and control signals every cycle. Its rs1/rs2/rd and write-enable outputs feed the forwarding unit and the EX operand muxes. It stalls PC and IF/ID for one cycle on a load-use dependency and injects a NOP bubble on a taken-branch flush.

---
 rtl/id_ex_stage_register_pkg.sv | 30 +++
 rtl/id_ex_stage_register_load_use_detector.sv | 29 ++
 rtl/id_ex_stage_register.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage_register.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_register_pkg.sv
// Shared pipeline definitions for the ID/EX, EX/MEM and MEM/WB stage registers.
//   ALU_OP_WIDTH : width of the ALU operation code
//   ALU_ADD      : ALU code carried by bubbles
//   ctrl_t       : control-bundle field ordering, reused by the later stage registers
//   CTRL_NOP     : control bundle of a bubble (nothing written, nothing accessed)
package id_ex_stage_register_pkg;

   localparam int unsigned ALU_OP_WIDTH = 4;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'b0000;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_src;
      logic branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      reg_write:  1'b0,
      mem_read:   1'b0,
      mem_write:  1'b0,
      mem_to_reg: 1'b0,
      alu_src:    1'b0,
      branch:     1'b0
   };

endpackage

// File: rtl/id_ex_stage_register_load_use_detector.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in EX is a load whose destination is read by the
// instruction currently in ID.
//   id_rs1_i, id_rs2_i         : source indices of the ID instruction
//   id_uses_rs1_i, id_uses_rs2_i : ID instruction really reads that source
//   ex_rd_i, ex_mem_read_i, ex_valid_i : destination / load flag / validity of EX
//   load_use_o                 : ID must wait one cycle for the load data
module id_ex_stage_register_load_use_detector (
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_uses_rs1_i,
   input  logic       id_uses_rs2_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_mem_read_i,
   input  logic       ex_valid_i,
   output logic       load_use_o
);

   logic rs1_match;
   logic rs2_match;

   always_comb begin
      rs1_match  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
      rs2_match  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
      // x0 is hardwired to zero, so a load "into" x0 never produces data to wait for.
      load_use_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_match || rs2_match);
   end

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Captures the decoded instruction every cycle; loads a bubble on a taken-branch
// flush or a load-use hazard, and counts bubbles (saturating).
//   clk, reset (async, active-low)
//   id_*            : decoded instruction from ID
//   flush_i         : taken branch/jump in EX, discard the ID instruction
//   ex_*            : registered copy of the instruction for EX / forwarding
//   ex_valid_o      : EX holds a real instruction
//   stall_o         : hold PC and IF/ID this cycle (combinational)
//   bubble_count_o  : saturating count of bubbles loaded since reset
module id_ex_stage_register #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ALU_OP_WIDTH = id_ex_stage_register_pkg::ALU_OP_WIDTH,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4:0]              id_rs1_i,
   input  logic [4:0]              id_rs2_i,
   input  logic [4:0]              id_rd_i,
   input  logic                    id_uses_rs1_i,
   input  logic                    id_uses_rs2_i,
   input  logic                    id_reg_write_i,
   input  logic                    id_mem_read_i,
   input  logic                    id_mem_write_i,
   input  logic                    id_mem_to_reg_i,
   input  logic                    id_alu_src_i,
   input  logic                    id_branch_i,
   input  logic [ALU_OP_WIDTH-1:0] id_alu_op_i,
   input  logic [DATA_WIDTH-1:0]   id_pc_i,
   input  logic [DATA_WIDTH-1:0]   id_rs1_data_i,
   input  logic [DATA_WIDTH-1:0]   id_rs2_data_i,
   input  logic [DATA_WIDTH-1:0]   id_imm_i,
   input  logic                    flush_i,
   output logic [4:0]              ex_rs1_o,
   output logic [4:0]              ex_rs2_o,
   output logic [4:0]              ex_rd_o,
   output logic                    ex_reg_write_o,
   output logic                    ex_mem_read_o,
   output logic                    ex_mem_write_o,
   output logic                    ex_mem_to_reg_o,
   output logic                    ex_alu_src_o,
   output logic                    ex_branch_o,
   output logic [ALU_OP_WIDTH-1:0] ex_alu_op_o,
   output logic [DATA_WIDTH-1:0]   ex_pc_o,
   output logic [DATA_WIDTH-1:0]   ex_rs1_data_o,
   output logic [DATA_WIDTH-1:0]   ex_rs2_data_o,
   output logic [DATA_WIDTH-1:0]   ex_imm_o,
   output logic                    ex_valid_o,
   output logic                    stall_o,
   output logic [CNT_WIDTH-1:0]    bubble_count_o
);

   import id_ex_stage_register_pkg::*;

   logic [4:0]              rs1_d, rs1_q;
   logic [4:0]              rs2_d, rs2_q;
   logic [4:0]              rd_d, rd_q;
   ctrl_t                   ctrl_d, ctrl_q;
   logic [ALU_OP_WIDTH-1:0] alu_op_d, alu_op_q;
   logic [DATA_WIDTH-1:0]   pc_d, pc_q;
   logic [DATA_WIDTH-1:0]   rs1_data_d, rs1_data_q;
   logic [DATA_WIDTH-1:0]   rs2_data_d, rs2_data_q;
   logic [DATA_WIDTH-1:0]   imm_d, imm_q;
   logic                    valid_d, valid_q;
   logic [CNT_WIDTH-1:0]    bubble_cnt_d, bubble_cnt_q;

   logic load_use;
   logic load_bubble;

   id_ex_stage_register_load_use_detector u_load_use_detector (
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_uses_rs1_i (id_uses_rs1_i),
      .id_uses_rs2_i (id_uses_rs2_i),
      .ex_rd_i       (rd_q),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_valid_i    (valid_q),
      .load_use_o    (load_use)
   );

   always_comb begin
      load_bubble = flush_i || load_use;
      // A flush discards the ID instruction anyway, so holding it would be pointless.
      stall_o     = load_use && !flush_i;

      // Bubble by default; index fields are zero so forwarding never matches a bubble.
      rs1_d      = 5'd0;
      rs2_d      = 5'd0;
      rd_d       = 5'd0;
      ctrl_d     = CTRL_NOP;
      alu_op_d   = ALU_OP_WIDTH'(ALU_ADD);
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      valid_d    = 1'b0;

      if (!load_bubble) begin
         rs1_d             = id_rs1_i;
         rs2_d             = id_rs2_i;
         rd_d              = id_rd_i;
         ctrl_d.reg_write  = id_reg_write_i;
         ctrl_d.mem_read   = id_mem_read_i;
         ctrl_d.mem_write  = id_mem_write_i;
         ctrl_d.mem_to_reg = id_mem_to_reg_i;
         ctrl_d.alu_src    = id_alu_src_i;
         ctrl_d.branch     = id_branch_i;
         alu_op_d          = id_alu_op_i;
         pc_d              = id_pc_i;
         rs1_data_d        = id_rs1_data_i;
         rs2_data_d        = id_rs2_data_i;
         imm_d             = id_imm_i;
         valid_d           = 1'b1;
      end

      bubble_cnt_d = bubble_cnt_q;
      if (load_bubble && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rs1_q        <= 5'd0;
         rs2_q        <= 5'd0;
         rd_q         <= 5'd0;
         ctrl_q       <= CTRL_NOP;
         alu_op_q     <= '0;
         pc_q         <= '0;
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
         valid_q      <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         ctrl_q       <= ctrl_d;
         alu_op_q     <= alu_op_d;
         pc_q         <= pc_d;
         rs1_data_q   <= rs1_data_d;
         rs2_data_q   <= rs2_data_d;
         imm_q        <= imm_d;
         valid_q      <= valid_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   always_comb begin
      ex_rs1_o        = rs1_q;
      ex_rs2_o        = rs2_q;
      ex_rd_o         = rd_q;
      ex_reg_write_o  = ctrl_q.reg_write;
      ex_mem_read_o   = ctrl_q.mem_read;
      ex_mem_write_o  = ctrl_q.mem_write;
      ex_mem_to_reg_o = ctrl_q.mem_to_reg;
      ex_alu_src_o    = ctrl_q.alu_src;
      ex_branch_o     = ctrl_q.branch;
      ex_alu_op_o     = alu_op_q;
      ex_pc_o         = pc_q;
      ex_rs1_data_o   = rs1_data_q;
      ex_rs2_data_o   = rs2_data_q;
      ex_imm_o        = imm_q;
      ex_valid_o      = valid_q;
      bubble_count_o  = bubble_cnt_q;
   end

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed self-checking bench for id_ex_stage_register.
module tb_id_ex_stage_register;
   import id_ex_stage_register_pkg::*;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_uses_rs1, id_uses_rs2;
   logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
   logic [3:0]  id_alu_op;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic        flush;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
   logic [3:0]  ex_alu_op;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic        ex_valid, stall;
   logic [15:0] bubble_count;

   int tests_run = 0;
   int tests_failed = 0;
   int unsigned exp_cnt = 0;

   id_ex_stage_register #(
      .DATA_WIDTH   (32),
      .ALU_OP_WIDTH (4),
      .CNT_WIDTH    (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs1_i        (id_rs1),
      .id_rs2_i        (id_rs2),
      .id_rd_i         (id_rd),
      .id_uses_rs1_i   (id_uses_rs1),
      .id_uses_rs2_i   (id_uses_rs2),
      .id_reg_write_i  (id_reg_write),
      .id_mem_read_i   (id_mem_read),
      .id_mem_write_i  (id_mem_write),
      .id_mem_to_reg_i (id_mem_to_reg),
      .id_alu_src_i    (id_alu_src),
      .id_branch_i     (id_branch),
      .id_alu_op_i     (id_alu_op),
      .id_pc_i         (id_pc),
      .id_rs1_data_i   (id_rs1_data),
      .id_rs2_data_i   (id_rs2_data),
      .id_imm_i        (id_imm),
      .flush_i         (flush),
      .ex_rs1_o        (ex_rs1),
      .ex_rs2_o        (ex_rs2),
      .ex_rd_o         (ex_rd),
      .ex_reg_write_o  (ex_reg_write),
      .ex_mem_read_o   (ex_mem_read),
      .ex_mem_write_o  (ex_mem_write),
      .ex_mem_to_reg_o (ex_mem_to_reg),
      .ex_alu_src_o    (ex_alu_src),
      .ex_branch_o     (ex_branch),
      .ex_alu_op_o     (ex_alu_op),
      .ex_pc_o         (ex_pc),
      .ex_rs1_data_o   (ex_rs1_data),
      .ex_rs2_data_o   (ex_rs2_data),
      .ex_imm_o        (ex_imm),
      .ex_valid_o      (ex_valid),
      .stall_o         (stall),
      .bubble_count_o  (bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain ALU instruction: reads nothing, writes nothing.
   task automatic id_clear();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
      id_mem_to_reg = 1'b0; id_alu_src = 1'b0; id_branch = 1'b0;
      id_alu_op = 4'h0; id_pc = 32'h0; id_rs1_data = 32'h0; id_rs2_data = 32'h0;
      id_imm = 32'h0; flush = 1'b0;
   endtask

   // Load word into rd.
   task automatic id_load(input logic [4:0] rd, input logic [4:0] base);
      id_clear();
      id_rd = rd; id_rs1 = base; id_uses_rs1 = 1'b1;
      id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_alu_src = 1'b1;
      id_pc = 32'h0000_0040; id_imm = 32'h0000_0008;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      id_clear();
      #2;
      tests_run++;
      if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || stall !== 1'b0 || bubble_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_initial: valid=%b rd=%0d stall=%b cnt=%0d want 0/0/0/0",
                  ex_valid, ex_rd, stall, bubble_count);
      end
      tick();
      reset = 1'b1;
      // Build nonzero state: one bubble, then a real instruction.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      id_rd = 5'd7; id_reg_write = 1'b1; id_pc = 32'h1234; id_imm = 32'h55;
      tick();
      tests_run++;
      if (ex_rd !== 5'd7 || ex_valid !== 1'b1 || bubble_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL reset_prestate: rd=%0d valid=%b cnt=%0d want 7/1/1",
                  ex_rd, ex_valid, bubble_count);
      end
      // Asynchronous reset away from any edge.
      #2;
      reset = 1'b0;
      #1;
      tests_run++;
      if (ex_rd !== 5'd0 || ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_pc !== 32'h0 ||
          ex_imm !== 32'h0 || bubble_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_async: rd=%0d valid=%b rw=%b pc=%h imm=%h cnt=%0d want all 0",
                  ex_rd, ex_valid, ex_reg_write, ex_pc, ex_imm, bubble_count);
      end
      @(negedge clk);
      reset = 1'b1;
      id_clear();
      id_rd = 5'd5; id_reg_write = 1'b1;
      tick();
      tests_run++;
      if (ex_rd !== 5'd5 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || bubble_count !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_first_load: rd=%0d valid=%b rw=%b cnt=%0d want 5/1/1/0",
                  ex_rd, ex_valid, ex_reg_write, bubble_count);
      end
      exp_cnt = 0;
   endtask

   task automatic test_load_use();
      id_load(5'd3, 5'd1);
      tick();
      id_clear();
      id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd9; id_uses_rs2 = 1'b1; id_rd = 5'd4;
      id_reg_write = 1'b1; id_alu_op = 4'h6; id_pc = 32'h0000_0100;
      id_rs1_data = 32'h0000_00AA; id_rs2_data = 32'h0000_00BB; id_imm = 32'h0000_0011;
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL lu_stall: stall=%b want 1", stall);
      end
      tick();
      exp_cnt++;
      tests_run++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
          ex_mem_to_reg !== 1'b0 || ex_alu_src !== 1'b0 || ex_rd !== 5'd0 || ex_rs1 !== 5'd0 ||
          ex_rs2 !== 5'd0 || ex_alu_op !== ALU_ADD || ex_pc !== 32'h0 || ex_rs1_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL lu_bubble: valid=%b rw=%b mr=%b rd=%0d rs1=%0d alu=%h pc=%h want bubble",
                  ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_rs1, ex_alu_op, ex_pc);
      end
      tests_run++;
      if (stall !== 1'b0 || bubble_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL lu_one_cycle: stall=%b cnt=%0d want 0/%0d", stall, bubble_count, exp_cnt);
      end
      tick();
      tests_run++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_rs1 !== 5'd3 || ex_rs2 !== 5'd9 ||
          ex_alu_op !== 4'h6 || ex_pc !== 32'h100 || ex_rs1_data !== 32'hAA ||
          ex_rs2_data !== 32'hBB || ex_imm !== 32'h11 || ex_reg_write !== 1'b1) begin
         tests_failed++;
         $display("FAIL lu_held_load: valid=%b rd=%0d alu=%h pc=%h d1=%h d2=%h imm=%h",
                  ex_valid, ex_rd, ex_alu_op, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm);
      end
   endtask

   task automatic test_no_hazard();
      id_load(5'd0, 5'd2);
      tick();
      id_clear();
      id_rs1 = 5'd0; id_uses_rs1 = 1'b1; id_rd = 5'd6; id_reg_write = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL nh_x0_stall: stall=%b want 0", stall);
      end
      tick();
      tests_run++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || bubble_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL nh_x0_load: valid=%b rd=%0d cnt=%0d want 1/6/%0d",
                  ex_valid, ex_rd, bubble_count, exp_cnt);
      end
      id_load(5'd3, 5'd1);
      tick();
      id_clear();
      id_rs2 = 5'd3; id_uses_rs2 = 1'b0; id_rd = 5'd8;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL nh_unused_rs2: stall=%b want 0", stall);
      end
      id_uses_rs2 = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL nh_used_rs2: stall=%b want 1", stall);
      end
      id_uses_rs2 = 1'b0;
      tick();
      tests_run++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || bubble_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL nh_unused_load: valid=%b rd=%0d cnt=%0d want 1/8/%0d",
                  ex_valid, ex_rd, bubble_count, exp_cnt);
      end
   endtask

   task automatic test_flush();
      id_clear();
      id_rd = 5'd10; id_reg_write = 1'b1; id_pc = 32'h200; flush = 1'b1;
      tick();
      exp_cnt++;
      tests_run++;
      if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0 || ex_pc !== 32'h0 ||
          bubble_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL fl_bubble: valid=%b rd=%0d rw=%b pc=%h cnt=%0d want 0/0/0/0/%0d",
                  ex_valid, ex_rd, ex_reg_write, ex_pc, bubble_count, exp_cnt);
      end
      id_load(5'd3, 5'd1);
      tick();
      id_clear();
      id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rd = 5'd11; id_reg_write = 1'b1; flush = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL fl_lu_stall: stall=%b want 0", stall);
      end
      tick();
      exp_cnt++;
      tests_run++;
      if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || bubble_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL fl_lu_bubble: valid=%b rd=%0d cnt=%0d want 0/0/%0d",
                  ex_valid, ex_rd, bubble_count, exp_cnt);
      end
      flush = 1'b0;
      tick();
      tests_run++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd11 || bubble_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL fl_lu_single: valid=%b rd=%0d cnt=%0d want 1/11/%0d",
                  ex_valid, ex_rd, bubble_count, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      id_load(5'd1, 5'd0);
      tick();
      id_load(5'd2, 5'd1);
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_stall1: stall=%b want 1", stall);
      end
      tick();
      exp_cnt++;
      tick();
      tests_run++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd2 || ex_mem_read !== 1'b1 ||
          bubble_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL b2b_load2: valid=%b rd=%0d mr=%b cnt=%0d want 1/2/1/%0d",
                  ex_valid, ex_rd, ex_mem_read, bubble_count, exp_cnt);
      end
      id_clear();
      id_rs2 = 5'd2; id_uses_rs2 = 1'b1; id_rd = 5'd12; id_reg_write = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_stall2: stall=%b want 1", stall);
      end
      tick();
      exp_cnt++;
      tick();
      tests_run++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || stall !== 1'b0 ||
          bubble_count !== 16'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL b2b_final: valid=%b rd=%0d stall=%b cnt=%0d want 1/12/0/%0d",
                  ex_valid, ex_rd, stall, bubble_count, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      id_clear();
      flush = 1'b1;
      repeat (65536 + 3) @(posedge clk);
      #1;
      tests_run++;
      if (bubble_count !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL sat_hold: cnt=%h want ffff", bubble_count);
      end
      tick();
      tests_run++;
      if (bubble_count !== 16'hFFFF || ex_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_no_wrap: cnt=%h valid=%b want ffff/0", bubble_count, ex_valid);
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_flush();
      test_back_to_back();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
